// File: rtl/commit_checker.sv
// Lockstep retirement checker: buffers golden and DUT commit records in two in-order
// FIFOs, compares one pair per cycle, and keeps saturating stats plus a first-mismatch capture.
module commit_checker #(
  parameter int data_bits  = 32,
  parameter int fifo_depth = 8,
  parameter int level_bits = $clog2(fifo_depth) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  gold_valid,
  input  logic [data_bits-1:0]  gold_pc,
  input  logic [4:0]            gold_rd,
  input  logic                  gold_reg_write,
  input  logic [data_bits-1:0]  gold_wdata,
  output logic                  gold_ready,
  input  logic                  dut_valid,
  input  logic [data_bits-1:0]  dut_pc,
  input  logic [4:0]            dut_rd,
  input  logic                  dut_reg_write,
  input  logic [data_bits-1:0]  dut_wdata,
  output logic                  dut_ready,
  output logic [level_bits-1:0] gold_level,
  output logic [level_bits-1:0] dut_level,
  output logic [31:0]           compare_count,
  output logic [15:0]           mismatch_count,
  output logic                  error,
  output logic                  overflow,
  output logic [data_bits-1:0]  first_bad_pc,
  output logic [data_bits-1:0]  first_bad_gold_wdata,
  output logic [data_bits-1:0]  first_bad_dut_wdata
);
  localparam int rec_bits = 2 * data_bits + 6;
  localparam int idx_bits = level_bits - 1;

  // Record layout is {pc, rd, reg_write, wdata}; x0 writes and non-writes ignore wdata.
  function automatic logic rec_match(input logic [rec_bits-1:0] g, input logic [rec_bits-1:0] d);
    logic [data_bits-1:0] g_pc, d_pc, g_wd, d_wd;
    logic [4:0]           g_rd, d_rd;
    logic                 g_rw, d_rw;
    {g_pc, g_rd, g_rw, g_wd} = g;
    {d_pc, d_rd, d_rw, d_wd} = d;
    rec_match = (g_pc == d_pc) && (g_rw == d_rw) &&
                (!g_rw || ((g_rd == d_rd) && ((g_rd == 5'd0) || (g_wd == d_wd))));
  endfunction

  logic [rec_bits-1:0]   r_gold_mem [fifo_depth];
  logic [rec_bits-1:0]   r_dut_mem  [fifo_depth];
  logic [level_bits-1:0] r_gold_wptr, r_gold_rptr, r_dut_wptr, r_dut_rptr;
  logic [31:0]           r_compare_count;
  logic [15:0]           r_mismatch_count;
  logic                  r_error, r_overflow;
  logic [data_bits-1:0]  r_first_bad_pc, r_first_bad_gold_wdata, r_first_bad_dut_wdata;

  logic [level_bits-1:0] w_gold_level, w_dut_level;
  logic                  w_gold_full, w_dut_full, w_gold_push, w_dut_push, w_pop, w_match;
  logic [rec_bits-1:0]   w_gold_head, w_dut_head;

  assign w_gold_level = r_gold_wptr - r_gold_rptr;
  assign w_dut_level  = r_dut_wptr - r_dut_rptr;
  assign w_gold_full  = (w_gold_level == level_bits'(fifo_depth));
  assign w_dut_full   = (w_dut_level == level_bits'(fifo_depth));
  // Fullness is judged before any same-cycle pop, so ready never depends on inputs.
  assign w_gold_push  = gold_valid && !w_gold_full && !clear;
  assign w_dut_push   = dut_valid && !w_dut_full && !clear;
  assign w_pop        = (w_gold_level != level_bits'(0)) && (w_dut_level != level_bits'(0)) && !clear;
  assign w_gold_head  = r_gold_mem[r_gold_rptr[idx_bits-1:0]];
  assign w_dut_head   = r_dut_mem[r_dut_rptr[idx_bits-1:0]];
  assign w_match      = rec_match(w_gold_head, w_dut_head);

  assign gold_ready           = !w_gold_full;
  assign dut_ready            = !w_dut_full;
  assign gold_level           = w_gold_level;
  assign dut_level            = w_dut_level;
  assign compare_count        = r_compare_count;
  assign mismatch_count       = r_mismatch_count;
  assign error                = r_error;
  assign overflow             = r_overflow;
  assign first_bad_pc         = r_first_bad_pc;
  assign first_bad_gold_wdata = r_first_bad_gold_wdata;
  assign first_bad_dut_wdata  = r_first_bad_dut_wdata;

  always_ff @(posedge clk) begin
    if (w_gold_push) r_gold_mem[r_gold_wptr[idx_bits-1:0]] <= {gold_pc, gold_rd, gold_reg_write, gold_wdata};
    if (w_dut_push)  r_dut_mem[r_dut_wptr[idx_bits-1:0]]   <= {dut_pc, dut_rd, dut_reg_write, dut_wdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gold_wptr <= '0;
      r_gold_rptr <= '0;
      r_dut_wptr  <= '0;
      r_dut_rptr  <= '0;
      r_overflow  <= 1'b0;
    end else if (clear) begin
      r_gold_wptr <= '0;
      r_gold_rptr <= '0;
      r_dut_wptr  <= '0;
      r_dut_rptr  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_gold_push) r_gold_wptr <= r_gold_wptr + level_bits'(1);
      if (w_dut_push)  r_dut_wptr  <= r_dut_wptr + level_bits'(1);
      if (w_pop) begin
        r_gold_rptr <= r_gold_rptr + level_bits'(1);
        r_dut_rptr  <= r_dut_rptr + level_bits'(1);
      end
      if ((gold_valid && w_gold_full) || (dut_valid && w_dut_full)) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_compare_count        <= 32'd0;
      r_mismatch_count       <= 16'd0;
      r_error                <= 1'b0;
      r_first_bad_pc         <= '0;
      r_first_bad_gold_wdata <= '0;
      r_first_bad_dut_wdata  <= '0;
    end else if (clear) begin
      r_compare_count        <= 32'd0;
      r_mismatch_count       <= 16'd0;
      r_error                <= 1'b0;
      r_first_bad_pc         <= '0;
      r_first_bad_gold_wdata <= '0;
      r_first_bad_dut_wdata  <= '0;
    end else if (w_pop) begin
      if (r_compare_count != 32'hFFFF_FFFF) r_compare_count <= r_compare_count + 32'd1;
      if (!w_match) begin
        if (r_mismatch_count != 16'hFFFF) r_mismatch_count <= r_mismatch_count + 16'd1;
        if (!r_error) begin
          r_error                <= 1'b1;
          r_first_bad_pc         <= w_gold_head[rec_bits-1 -: data_bits];
          r_first_bad_gold_wdata <= w_gold_head[data_bits-1:0];
          r_first_bad_dut_wdata  <= w_dut_head[data_bits-1:0];
        end
      end
    end
  end
endmodule
